// File: rtl/writeback_if.sv
// Execute-to-writeback handoff plus the data-memory request/response bus.
// The slave modport is the writeback stage; master is execute + memory.
interface writeback_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] wb_result;
  logic        wb_alu_to_reg;
  logic        wb_mem_to_reg;
  logic        wb_mem_write;
  logic [4:0]  wb_dest_reg_sel;
  logic [2:0]  wb_alu_operation;
  logic [31:0] ld_address;
  logic [31:0] wb_write_address;
  logic [3:0]  wb_write_byte;
  logic [31:0] wb_write_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport slave (
    input  in_valid, wb_result, wb_alu_to_reg, wb_mem_to_reg, wb_mem_write,
           wb_dest_reg_sel, wb_alu_operation, ld_address,
           wb_write_address, wb_write_byte, wb_write_data,
           dmem_ack, dmem_rdata,
    output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata
  );

  modport master (
    output in_valid, wb_result, wb_alu_to_reg, wb_mem_to_reg, wb_mem_write,
           wb_dest_reg_sel, wb_alu_operation, ld_address,
           wb_write_address, wb_write_byte, wb_write_data,
           dmem_ack, dmem_rdata,
    input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata
  );
endinterface

// File: rtl/writeback.sv
// Writeback stage: ALU results, load alignment and store issue to data memory.
// Define WB_INSTRET_EN to build the retired-instruction counter.
module writeback (
  input  logic        clk,
  input  logic        reset,
  writeback_if.slave  bus,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        misalign_err,
  output logic [31:0] instret
);
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WAIT} state_t;
  state_t state, state_nx;

  logic        accept, is_store, is_load, ld_misal;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic [4:0]  ld_dest;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_off;
  logic [31:0] ld_data;
  logic        ld_ok;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        unused_addr_lsb;

  assign bus.in_ready   = (state == IDLE);
  assign bus.dmem_req   = req_q;
  assign bus.dmem_we    = we_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_wstrb = wstrb_q;
  assign bus.dmem_wdata = wdata_q;
  assign unused_addr_lsb = ^bus.wb_write_address[1:0];

  assign accept   = bus.in_valid && (state == IDLE);
  assign is_store = bus.wb_mem_write;
  assign is_load  = !bus.wb_mem_write && bus.wb_mem_to_reg;

  always_comb begin
    ld_misal = 1'b0;
    case (bus.wb_alu_operation)
      3'd2:       ld_misal = (bus.ld_address[1:0] != 2'd0);
      3'd1, 3'd5: ld_misal = (bus.ld_address[1:0] == 2'd3);
      default:    ld_misal = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:
        if (accept) begin
          if (is_store)                 state_nx = STORE_WAIT;
          else if (is_load && !ld_misal) state_nx = LOAD_WAIT;
        end
      LOAD_WAIT:  if (bus.dmem_ack) state_nx = IDLE;
      STORE_WAIT: if (bus.dmem_ack) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // Lane select uses the offset latched at issue, not the live address.
  always_comb begin
    ld_byte = bus.dmem_rdata[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    ld_ok   = 1'b1;
    ld_data = '0;
    case (ld_f3)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd5:    ld_data = {16'd0, ld_half};
      3'd2:    ld_data = bus.dmem_rdata;
      default: ld_ok   = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      misalign_err <= 1'b0;
      ld_dest      <= '0;
      ld_f3        <= '0;
      ld_off       <= '0;
    end else begin
      state        <= state_nx;
      rf_we        <= 1'b0;
      misalign_err <= 1'b0;
      if (accept) begin
        if (is_store) begin
          req_q   <= 1'b1;
          we_q    <= 1'b1;
          addr_q  <= {bus.wb_write_address[31:2], 2'b00};
          wstrb_q <= bus.wb_write_byte;
          wdata_q <= bus.wb_write_data;
        end else if (is_load) begin
          if (ld_misal) begin
            misalign_err <= 1'b1;
          end else begin
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= {bus.ld_address[31:2], 2'b00};
            ld_dest <= bus.wb_dest_reg_sel;
            ld_f3   <= bus.wb_alu_operation;
            ld_off  <= bus.ld_address[1:0];
          end
        end else begin
          rf_we    <= bus.wb_alu_to_reg && (bus.wb_dest_reg_sel != 5'd0);
          rf_waddr <= bus.wb_dest_reg_sel;
          rf_wdata <= bus.wb_result;
        end
      end
      if (state == LOAD_WAIT && bus.dmem_ack) begin
        req_q <= 1'b0;
        if (ld_ok) begin
          rf_we    <= (ld_dest != 5'd0);
          rf_waddr <= ld_dest;
          rf_wdata <= ld_data;
        end
      end
      if (state == STORE_WAIT && bus.dmem_ack) req_q <= 1'b0;
    end
  end

`ifdef WB_INSTRET_EN
  logic        retire;
  logic [31:0] instret_q;
  // Misaligned loads are accepted but never retire.
  assign retire = (accept && !is_store && !is_load) ||
                  (state != IDLE && bus.dmem_ack);
  always_ff @(posedge clk) begin
    if (reset)       instret_q <= '0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end
  assign instret = instret_q;
`else
  assign instret = '0;
`endif
endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: scoreboarded rf writes, memory handshakes,
// misalignment, reset abort and (when built with it) the retire counter.
module tb_writeback;
  logic        clk = 1'b0;
  logic        reset;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        misalign_err;
  logic [31:0] instret;

  writeback_if bus();

  writeback dut (
    .clk(clk), .reset(reset), .bus(bus),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .misalign_err(misalign_err), .instret(instret)
  );

  always #5 clk = ~clk;

`ifdef WB_INSTRET_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] ret_cnt = '0;
  logic [36:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1ns after the edge, retire any rf write against the scoreboard.
  task automatic tick();
    logic [36:0] e;
    @(posedge clk);
    #1;
    if (rf_we === 1'b1) begin
      if (sb.size() == 0) chk("rf_we_unexpected", {31'd0, rf_we}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("sb_waddr", {27'd0, rf_waddr}, {27'd0, e[36:32]});
        chk("sb_wdata", rf_wdata, e[31:0]);
      end
    end
  endtask

  task automatic chk_instret(input string tag);
    chk(tag, instret, CNT_EN ? ret_cnt : 32'd0);
  endtask

  task automatic alu(input logic [4:0] dest, input logic [31:0] res, input logic a2r);
    bus.in_valid = 1'b1;  bus.wb_mem_write = 1'b0; bus.wb_mem_to_reg = 1'b0;
    bus.wb_alu_to_reg = a2r; bus.wb_dest_reg_sel = dest; bus.wb_result = res;
    if (a2r && dest != 5'd0) sb.push_back({dest, res});
    ret_cnt = ret_cnt + 32'd1;
    tick();
    bus.in_valid = 1'b0;
    chk("alu_rf_we", {31'd0, rf_we}, {31'd0, (a2r && dest != 5'd0)});
    chk("alu_waddr", {27'd0, rf_waddr}, {27'd0, dest});
    chk("alu_wdata", rf_wdata, res);
    chk("alu_ready", {31'd0, bus.in_ready}, 32'd1);
    chk_instret("alu_instret");
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] dest,
                      input int lat, input logic [31:0] rdata, input logic [31:0] exp_data,
                      input logic writes);
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    bus.in_valid = 1'b1; bus.wb_mem_write = 1'b0; bus.wb_mem_to_reg = 1'b1;
    bus.wb_alu_operation = f3; bus.ld_address = addr; bus.wb_dest_reg_sel = dest;
    tick();
    bus.in_valid = 1'b0; bus.wb_mem_to_reg = 1'b0;
    chk("ld_req", {31'd0, bus.dmem_req}, 32'd1);
    chk("ld_we", {31'd0, bus.dmem_we}, 32'd0);
    chk("ld_addr", bus.dmem_addr, exp_addr);
    chk("ld_ready", {31'd0, bus.in_ready}, 32'd0);
    for (int i = 1; i < lat; i++) begin
      tick();
      chk("ld_hold_req", {31'd0, bus.dmem_req}, 32'd1);
      chk("ld_hold_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.dmem_ack = 1'b1; bus.dmem_rdata = rdata;
    if (writes && dest != 5'd0) sb.push_back({dest, exp_data});
    ret_cnt = ret_cnt + 32'd1;
    tick();
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'hDEADDEAD;
    chk("ld_done_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("ld_done_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("ld_rf_we", {31'd0, rf_we}, {31'd0, (writes && dest != 5'd0)});
    if (writes && dest != 5'd0) chk("ld_data", rf_wdata, exp_data);
    chk_instret("ld_instret");
  endtask

  task automatic store(input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] data, input int lat);
    bus.in_valid = 1'b1; bus.wb_mem_write = 1'b1; bus.wb_mem_to_reg = 1'b1;
    bus.wb_write_address = addr; bus.wb_write_byte = strb; bus.wb_write_data = data;
    bus.ld_address = 32'h0000_0FF0;
    tick();
    bus.in_valid = 1'b0; bus.wb_mem_write = 1'b0; bus.wb_mem_to_reg = 1'b0;
    for (int i = 0; i < lat; i++) begin
      if (i > 0) tick();
      chk("st_req", {31'd0, bus.dmem_req}, 32'd1);
      chk("st_we", {31'd0, bus.dmem_we}, 32'd1);
      chk("st_addr", bus.dmem_addr, {addr[31:2], 2'b00});
      chk("st_wstrb", {28'd0, bus.dmem_wstrb}, {28'd0, strb});
      chk("st_wdata", bus.dmem_wdata, data);
      chk("st_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.dmem_ack = 1'b1;
    ret_cnt = ret_cnt + 32'd1;
    tick();
    bus.dmem_ack = 1'b0;
    chk("st_done_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("st_rf_we", {31'd0, rf_we}, 32'd0);
    chk("st_done_ready", {31'd0, bus.in_ready}, 32'd1);
    chk_instret("st_instret");
  endtask

  task automatic misal(input logic [2:0] f3, input logic [31:0] addr);
    bus.in_valid = 1'b1; bus.wb_mem_write = 1'b0; bus.wb_mem_to_reg = 1'b1;
    bus.wb_alu_operation = f3; bus.ld_address = addr; bus.wb_dest_reg_sel = 5'd9;
    tick();
    bus.in_valid = 1'b0; bus.wb_mem_to_reg = 1'b0;
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("mis_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("mis_rf_we", {31'd0, rf_we}, 32'd0);
    chk_instret("mis_instret");
    tick();
    chk("mis_err_pulse", {31'd0, misalign_err}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.wb_result = '0; bus.wb_alu_to_reg = 1'b0;
    bus.wb_mem_to_reg = 1'b0; bus.wb_mem_write = 1'b0; bus.wb_dest_reg_sel = '0;
    bus.wb_alu_operation = '0; bus.ld_address = '0; bus.wb_write_address = '0;
    bus.wb_write_byte = '0; bus.wb_write_data = '0; bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("rst_addr", bus.dmem_addr, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_misal", {31'd0, misalign_err}, 32'd0);
    chk("rst_instret", instret, 32'd0);

    alu(5'd5, 32'h1234_5678, 1'b1);
    tick();
    chk("alu_pulse", {31'd0, rf_we}, 32'd0);
    chk("alu_hold_wdata", rf_wdata, 32'h1234_5678);
    alu(5'd0, 32'hCAFE_0001, 1'b1);
    alu(5'd7, 32'h0BAD_F00D, 1'b0);
    alu(5'd31, 32'hFFFF_FFFF, 1'b1);

    load(3'd0, 32'h103, 5'd3, 3, 32'h80AA_BBCC, 32'hFFFF_FF80, 1'b1);
    load(3'd4, 32'h103, 5'd4, 3, 32'h80AA_BBCC, 32'h0000_0080, 1'b1);
    load(3'd0, 32'h101, 5'd6, 2, 32'h80AA_BBCC, 32'hFFFF_FFBB, 1'b1);
    load(3'd1, 32'h102, 5'd8, 1, 32'h80AA_BBCC, 32'hFFFF_80AA, 1'b1);
    load(3'd5, 32'h100, 5'd10, 2, 32'h80AA_BBCC, 32'h0000_BBCC, 1'b1);
    load(3'd1, 32'h100, 5'd11, 1, 32'h0000_7FFF, 32'h0000_7FFF, 1'b1);
    load(3'd2, 32'h100, 5'd12, 1, 32'h80AA_BBCC, 32'h80AA_BBCC, 1'b1);
    load(3'd3, 32'h100, 5'd13, 2, 32'h1111_2222, 32'h0, 1'b0);
    load(3'd0, 32'h100, 5'd0, 1, 32'h1111_2222, 32'h0, 1'b0);

    store(32'h206, 4'b1100, 32'hBEEF_BEEF, 2);
    store(32'h3FB, 4'b0001, 32'h0000_00A5, 1);

    misal(3'd2, 32'h102);
    misal(3'd1, 32'h103);
    misal(3'd5, 32'h103);

    // Stray ack while idle must not produce a write or a retire.
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h5555_5555;
    tick();
    bus.dmem_ack = 1'b0;
    chk("idle_ack_rf_we", {31'd0, rf_we}, 32'd0);
    chk("idle_ack_ready", {31'd0, bus.in_ready}, 32'd1);
    chk_instret("idle_ack_instret");

    // Reset in LOAD_WAIT together with ack abandons the load.
    bus.in_valid = 1'b1; bus.wb_mem_to_reg = 1'b1; bus.wb_alu_operation = 3'd2;
    bus.ld_address = 32'h400; bus.wb_dest_reg_sel = 5'd14;
    tick();
    bus.in_valid = 1'b0; bus.wb_mem_to_reg = 1'b0;
    chk("rl_req", {31'd0, bus.dmem_req}, 32'd1);
    reset = 1'b1; bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h7777_7777;
    tick();
    reset = 1'b0; bus.dmem_ack = 1'b0;
    ret_cnt = '0;
    chk("rl_req_clr", {31'd0, bus.dmem_req}, 32'd0);
    chk("rl_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rl_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rl_instret", instret, 32'd0);
    tick();
    chk("rl_rf_we2", {31'd0, rf_we}, 32'd0);

    alu(5'd2, 32'h0000_0042, 1'b1);
`ifdef WB_INSTRET_EN
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    ret_cnt = 32'hFFFF_FFFF;
    alu(5'd1, 32'h0000_0001, 1'b1);
    chk("instret_wrap", instret, 32'd0);
`endif

    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
